sobel_window_sequencer: RTL and testbench

SOBEL_WINDOW_SEQUENCER -- requirements
Module: sobel_window_sequencer

---
 rtl/sobel_window_sequencer_if.sv | 32 +++
 rtl/sobel_window_sequencer.sv | 146 ++++++++++++++
 tb/tb_sobel_window_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_sequencer_if.sv
// Handshake bundle for sobel_window_sequencer.
//   in_*   : raster pixel stream into the sequencer (valid/ready)
//   win_*  : window issue to an external kernel, core_result returned with win_done
//   out_*  : edge result stream out (valid/ready), out_last marks frame end
//   frame_done : one-cycle pulse after the last result of a frame is taken
// slave  = the sequencer, master = the environment around it.
interface sobel_window_sequencer_if #(
    parameter int PIX_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [PIX_W-1:0]   in_pixel;
    logic               win_start;
    logic [8*PIX_W-1:0] win_pixels;
    logic               win_done;
    logic [PIX_W-1:0]   core_result;
    logic               out_valid;
    logic               out_ready;
    logic [PIX_W-1:0]   out_pixel;
    logic               out_last;
    logic               frame_done;

    modport slave (
        input  in_valid, in_pixel, win_done, core_result, out_ready,
        output in_ready, win_start, win_pixels, out_valid, out_pixel, out_last, frame_done
    );

    modport master (
        output in_valid, in_pixel, win_done, core_result, out_ready,
        input  in_ready, win_start, win_pixels, out_valid, out_pixel, out_last, frame_done
    );
endinterface

// File: rtl/sobel_window_sequencer.sv
// Sobel window sequencer: turns a raster pixel stream into 3x3 windows, hands
// each window to an external kernel and streams the kernel results out.
// Ports:
//   clk, reset : single clock, synchronous active-high reset
//   bus        : sobel_window_sequencer_if.slave (pixel in, window issue,
//                kernel result, result out, frame_done)
// One window is in flight at a time: FILL accepts pixels, ISSUE pulses
// win_start, WAIT holds for win_done, OUTPUT holds the result until taken.
module sobel_window_sequencer #(
    parameter int COLS  = 144,
    parameter int ROWS  = 147,
    parameter int PIX_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    sobel_window_sequencer_if.slave bus
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    typedef enum logic [1:0] {ST_FILL, ST_ISSUE, ST_WAIT, ST_OUTPUT} state_t;

    state_t state, state_nx;

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             accept, col_end, row_end, completes;
    logic             in_ready_c, win_start_c, out_valid_c;

    // lb_row1 holds the previous image row, lb_row2 the one before it.
    logic [PIX_W-1:0] lb_row1 [COLS];
    logic [PIX_W-1:0] lb_row2 [COLS];

    // win[r][c]: r=0 top row, c=0 leftmost (oldest) column.
    logic [2:0][2:0][PIX_W-1:0] win;
    logic             win_last;

    logic [PIX_W-1:0] out_pixel_q;
    logic             out_last_q;
    logic             frame_done_q;

    assign col_end   = (col == CW'(COLS - 1));
    assign row_end   = (row == RW'(ROWS - 1));
    assign completes = (row >= RW'(2)) && (col >= CW'(2));
    assign accept    = bus.in_valid && in_ready_c;

    // Position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers are never cleared; the row counter restarting at 0 means
    // nothing stale reaches a window before both rows are rewritten.
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            lb_row2[col] <= lb_row1[col];
            lb_row1[col] <= bus.in_pixel;
        end
    end

    // Shift the window left by one column and load the new column:
    // two rows up from the line buffers, the bottom from the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            win      <= '0;
            win_last <= 1'b0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb_row2[col];
            win[1][2] <= lb_row1[col];
            win[2][2] <= bus.in_pixel;
            win_last  <= row_end && col_end;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_FILL;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        in_ready_c  = 1'b0;
        win_start_c = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            ST_FILL: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && completes) state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                win_start_c = 1'b1;
                state_nx    = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.win_done) state_nx = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nx = ST_FILL;
            end
            default: state_nx = ST_FILL;
        endcase
    end

    // Result capture only in WAIT, so stray win_done pulses elsewhere
    // (including a late one from before a reset) are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_pixel_q  <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= (state == ST_OUTPUT) && bus.out_ready && out_last_q;
            if (state == ST_WAIT && bus.win_done) begin
                out_pixel_q <= bus.core_result;
                out_last_q  <= win_last;
            end else if (state == ST_OUTPUT && bus.out_ready) begin
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.win_start  = win_start_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_pixel  = out_pixel_q;
    assign bus.out_last   = out_last_q;
    assign bus.frame_done = frame_done_q;
    // p1,p2,p3,p4,p6,p7,p8,p9 with p1 in the LSBs; centre excluded.
    assign bus.win_pixels = {win[2][2], win[2][1], win[2][0], win[1][2],
                             win[1][0], win[0][2], win[0][1], win[0][0]};
endmodule

// File: tb/tb_sobel_window_sequencer.sv
module tb_sobel_window_sequencer;
    localparam int COLS  = 8;
    localparam int ROWS  = 7;
    localparam int PIX_W = 8;
    localparam int NRES  = (ROWS - 2) * (COLS - 2);

    typedef struct {
        logic [7:0] pix;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sobel_window_sequencer_if #(.PIX_W(PIX_W)) bus ();

    sobel_window_sequencer #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   failures = 0;
    int   res_cnt = 0;
    int   fd_count = 0;
    int   acc_cnt = 0;
    bit   abort = 0, noise_en = 0, long_delay = 0, kern_abort = 0;
    bit   kern_busy = 0, drv_busy = 0, stall_req = 0, stall_done = 0, fd_expect = 0;
    bit   cmd_q [$];
    exp_t exp_q [$];
    logic [7:0] img [ROWS][COLS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input string act, input string req);
        checks++;
        failures++;
        $display("FAIL %s actual=%s required=%s", name, act, req);
    endtask

    // Kernel function used by both the kernel stand-in and the reference:
    // a weighted sum with distinct odd weights so any misplaced pixel shows up.
    function automatic logic [7:0] kfun(input logic [63:0] w);
        int acc;
        int coef [8];
        coef = '{1, 3, 5, 7, 11, 13, 17, 19};
        acc = 0;
        for (int k = 0; k < 8; k++) acc += coef[k] * int'(w[8*k +: 8]);
        return acc[7:0];
    endfunction

    task automatic new_image();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                img[r][c] = 8'($urandom_range(0, 255));
    endtask

    // Reference: one result per interior centre, raster order, last flagged.
    task automatic push_expected();
        exp_t e;
        logic [63:0] w;
        for (int r = 1; r < ROWS - 1; r++)
            for (int c = 1; c < COLS - 1; c++) begin
                w = {img[r+1][c+1], img[r+1][c], img[r+1][c-1], img[r][c+1],
                     img[r][c-1], img[r-1][c+1], img[r-1][c], img[r-1][c-1]};
                e.pix  = kfun(w);
                e.last = (r == ROWS - 2) && (c == COLS - 2);
                exp_q.push_back(e);
            end
    endtask

    task automatic drive_one(input bit gaps);
        int t;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    bus.in_valid = 1'b0;
                    @(negedge clk);
                end
                bus.in_valid = 1'b1;
                bus.in_pixel = img[r][c];
                t = 0;
                while (!bus.in_ready) begin
                    @(negedge clk);
                    t++;
                    if (abort) return;
                    if (t > 2000) begin
                        fail_now("in_ready_timeout", "stuck_low", "high");
                        return;
                    end
                end
                if (abort) return;
                acc_cnt++;
                @(negedge clk);
            end
    endtask

    // Driver: consumes frame commands back to back, so consecutive commands
    // keep in_valid high across the frame boundary.
    initial begin : driver
        bit g;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        forever begin
            while (cmd_q.size() != 0) begin
                g = cmd_q.pop_front();
                drv_busy = 1;
                acc_cnt = 0;
                drive_one(g);
            end
            bus.in_valid = 1'b0;
            drv_busy = 0;
            @(negedge clk);
        end
    end

    // Kernel stand-in: answers each win_start after a random delay, checks the
    // window holds still while waiting, and throws stray win_done pulses in
    // FILL, ISSUE and OUTPUT.
    initial begin : kernel
        logic [63:0] wp;
        int d;
        bus.win_done = 1'b0;
        bus.core_result = '0;
        forever begin
            @(negedge clk);
            bus.win_done = 1'b0;
            if (bus.win_start === 1'b1) begin
                wp = bus.win_pixels;
                kern_busy = 1;
                if (noise_en && $urandom_range(0, 1) == 1) begin
                    bus.win_done = 1'b1;
                    bus.core_result = 8'($urandom);
                end
                d = long_delay ? 8 : $urandom_range(1, 6);
                for (int i = 1; i <= d; i++) begin
                    @(negedge clk);
                    if (!kern_abort) check("win_pixels_stable", bus.win_pixels, wp);
                    bus.win_done = (i == d);
                    bus.core_result = (i == d) ? kfun(wp) : 8'($urandom);
                end
                kern_busy = 0;
            end else if (noise_en && $urandom_range(0, 3) == 0) begin
                bus.win_done = 1'b1;
                bus.core_result = 8'($urandom);
            end
        end
    end

    // Monitor: owns out_ready; a handshake is decided at the negedge and
    // completes on the following posedge.
    initial begin : monitor
        exp_t e;
        logic [7:0] held;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.frame_done || fd_expect) check("frame_done_pulse", bus.frame_done, fd_expect);
            if (bus.frame_done) fd_count++;
            fd_expect = 0;
            if (stall_req && !stall_done && bus.out_valid) begin
                bus.out_ready = 1'b0;
                held = bus.out_pixel;
                repeat (10) begin
                    @(negedge clk);
                    check("stall_out_valid", bus.out_valid, 1);
                    check("stall_out_pixel", bus.out_pixel, held);
                    check("stall_in_ready", bus.in_ready, 0);
                    check("stall_win_start", bus.win_start, 0);
                end
                stall_done = 1;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result", "extra_output", "none");
                end else begin
                    e = exp_q.pop_front();
                    check("out_pixel", bus.out_pixel, e.pix);
                    check("out_last", bus.out_last, e.last);
                    fd_expect = e.last;
                end
                res_cnt++;
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},   bus.in_ready, 1);
        check({tag, "_out_valid"},  bus.out_valid, 0);
        check({tag, "_win_start"},  bus.win_start, 0);
        check({tag, "_frame_done"}, bus.frame_done, 0);
        check({tag, "_out_last"},   bus.out_last, 0);
        check({tag, "_out_pixel"},  bus.out_pixel, 0);
        check({tag, "_win_pixels"}, bus.win_pixels, 0);
    endtask

    task automatic run_frames(input int n, input bit gaps);
        int fd0, r0, t;
        fd0 = fd_count;
        r0 = res_cnt;
        t = 0;
        new_image();
        for (int i = 0; i < n; i++) begin
            push_expected();
            cmd_q.push_back(gaps);
        end
        while ((cmd_q.size() != 0 || drv_busy || exp_q.size() != 0) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) fail_now("drain_timeout", "results_pending", "drained");
        repeat (3) @(negedge clk);
        check("result_count", 64'(res_cnt - r0), 64'(n * NRES));
        check("frame_done_count", 64'(fd_count - fd0), 64'(n));
    endtask

    initial begin : main
        int t;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("init");
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", bus.in_ready, 1);
        noise_en = 1;

        run_frames(1, 1);
        stall_req = 1;
        run_frames(1, 1);
        check("stall_exercised", stall_done, 1);
        run_frames(1, 1);

        // Reset while the window centred on row 4 (completed by row 5) waits.
        new_image();
        push_expected();
        long_delay = 1;
        cmd_q.push_back(1'b1);
        t = 0;
        while (!(acc_cnt >= 5 * COLS + 3 && kern_busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) fail_now("row5_wait_timeout", "not_reached", "wait_at_row5");
        @(negedge clk);
        reset = 1'b1;
        abort = 1;
        kern_abort = 1;
        exp_q.delete();
        @(negedge clk);
        check_reset("mid_wait");
        @(negedge clk);
        reset = 1'b0;
        t = 0;
        while ((drv_busy || kern_busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail_now("abort_settle_timeout", "busy", "idle");
        abort = 0;
        kern_abort = 0;
        long_delay = 0;
        @(negedge clk);
        check("in_ready_after_abort", bus.in_ready, 1);
        check("out_valid_after_abort", bus.out_valid, 0);
        run_frames(1, 1);

        // Two identical frames with in_valid held high across the boundary.
        run_frames(2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
